lsu_mem_arbiter: RTL
====================

Name: lsu_mem_arbiter

Overview:
- Shares one external data-memory port between the per-thread LSUs of a core.
- Accepts read/write requests from NUM_CONSUMERS LSUs and grants them round-robin, one transaction at a time.
- Performs the valid/ready handshake with memory and returns a one-cycle ready pulse, plus read data, to the granted LSU.
- Sits between the LSU array of a core and the device memory.

Parameters:
NUM_CONSUMERS, 4, number of LSU requesters (>=2)
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request, held until ready seen
consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  output  NUM_CONSUMERS  per-LSU read-complete pulse
consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, valid with ready
consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request
consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses
consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data
consumer_write_ready  output  NUM_CONSUMERS  per-LSU write-complete pulse
mem_read_valid  output  1  read request to memory
mem_read_address  output  ADDR_BITS  read address to memory
mem_read_ready  input  1  memory read-complete
mem_read_data  input  DATA_BITS  memory read data, valid with mem_read_ready
mem_write_valid  output  1  write request to memory
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  memory write-complete
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous) clears everything:
  - All outputs are 0, including all consumer ready/data, all mem valid/address/data, and busy.
  - The FSM goes to IDLE, the round-robin pointer to 0, and grant to 0.
- Reset asserted mid-transaction abandons it. No ready pulse is issued afterwards.
- FSM states: IDLE, MEM_REQ, RESPOND, RELEASE.
- IDLE:
  - A consumer is requesting if its read_valid or write_valid is high.
  - Scan from the pointer upward with wrap-around (ptr, ptr+1, ..., NUM_CONSUMERS-1, 0, ...). The first requesting consumer wins and is latched as grant.
  - Latch the direction. Read takes priority if both valids are high for the winner.
  - Latch the address, and the data for writes.
  - Assert the matching mem_*_valid with the latched address/data, then go to MEM_REQ.
  - With no requester, stay in IDLE with outputs unchanged.
- MEM_REQ:
  - Hold mem valid, address and data stable until the matching mem ready is sampled high.
  - On ready: deassert mem valid. For a read, capture mem_read_data into the grant's consumer_read_data slot. Go to RESPOND.
  - Ready on the non-matching channel is ignored.
- RESPOND:
  - Drive consumer_read_ready[grant] or consumer_write_ready[grant] high for exactly this one cycle.
  - consumer_read_data holds its value until overwritten by a later read to the same consumer.
  - Go to RELEASE.
- RELEASE:
  - Wait until both consumer_read_valid[grant] and consumer_write_valid[grant] are low. This prevents re-servicing the same request while the LSU drops valid one cycle late.
  - Then set pointer = grant+1 (mod NUM_CONSUMERS) and go to IDLE.
- Latency, uncontended read: the request is sampled at edge 0, mem valid is high after edge 0, mem ready arrives at edge k, the consumer ready pulse follows at edge k+1, and the next grant is possible at edge k+3.
- At most one memory transaction is outstanding. mem_read_valid and mem_write_valid are never both high.
- A requester toggling valid while not granted has no effect. Request fields are sampled only at grant.
- Fairness: under continuous requests from all consumers, each one is served once per NUM_CONSUMERS transactions.

Test Plan:
- Single read: consumer 2 requests address 0x10, memory returns 0xA5 after 3 cycles → mem_read_address=0x10; consumer_read_ready[2] pulses for 1 cycle exactly one cycle after mem_read_ready, with data slot 2 = 0xA5. No other ready bit moves.
- Single write: consumer 1 writes 0x3C to address 0x20 → mem_write_address=0x20 and mem_write_data=0x3C, held until mem_write_ready. consumer_write_ready[1] then pulses once.
- Contention: all 4 consumers request reads at 0x00..0x03 simultaneously from reset → grants in order 0,1,2,3. mem_read_address sequence is 0x00,0x01,0x02,0x03. Each consumer gets exactly one ready pulse.
- Round-robin wrap: after serving consumer 3, consumers 0 and 3 both request → consumer 0 is granted first.
- Held valid: consumer 0 keeps read_valid high for 2 cycles after its ready pulse → no second memory request is issued until valid drops. busy stays high until then.
- Reset mid-op: assert reset while in MEM_REQ → mem_read_valid=0, busy=0 and no ready pulse. After release, a new request is granted starting from consumer 0.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the per-thread LSUs.
// One transaction at a time: grant, memory handshake, one-cycle ready pulse, release.
module lsu_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,

    output logic                                 busy
);

    localparam int CW = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e                           state_q, state_d;
    logic [CW-1:0]                    grant_q, grant_d;
    logic [CW-1:0]                    ptr_q, ptr_d;
    logic                             is_read_q, is_read_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic                             mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]             mem_read_address_q, mem_read_address_d;
    logic [ADDR_BITS-1:0]             mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]             mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]         rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]         wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0]         req;
    logic                             found;
    logic [CW-1:0]                    win;
    logic                             sel_read;
    logic [ADDR_BITS-1:0]             sel_raddr;
    logic [ADDR_BITS-1:0]             sel_waddr;
    logic [DATA_BITS-1:0]             sel_wdata;
    logic                             grant_still_valid;

    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int unsigned off);
        return CW'((32'(base) + off) % 32'(NUM_CONSUMERS));
    endfunction

    // Scan upward from the pointer with wrap-around; first requester wins.
    always_comb begin
        req   = consumer_read_valid | consumer_write_valid;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && req[wrap_idx(ptr_q, i)]) begin
                found = 1'b1;
                win   = wrap_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        sel_read  = 1'b0;
        sel_raddr = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int unsigned j = 0; j < NUM_CONSUMERS; j++) begin
            if (CW'(j) == win) begin
                sel_read  = consumer_read_valid[j];
                sel_raddr = consumer_read_address[j*ADDR_BITS +: ADDR_BITS];
                sel_waddr = consumer_write_address[j*ADDR_BITS +: ADDR_BITS];
                sel_wdata = consumer_write_data[j*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign grant_still_valid = consumer_read_valid[grant_q] | consumer_write_valid[grant_q];

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        ptr_d               = ptr_q;
        is_read_d           = is_read_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        rd_ready_d          = '0;
        wr_ready_d          = '0;
        rd_data_d           = rd_data_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = win;
                    is_read_d = sel_read;
                    if (sel_read) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = sel_raddr;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = sel_waddr;
                        mem_write_data_d    = sel_wdata;
                    end
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                // Ready pulses are registered so they land exactly in RESPOND.
                if (is_read_q && mem_read_ready) begin
                    mem_read_valid_d    = 1'b0;
                    rd_ready_d[grant_q] = 1'b1;
                    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                        if (CW'(k) == grant_q) begin
                            rd_data_d[k*DATA_BITS +: DATA_BITS] = mem_read_data;
                        end
                    end
                    state_d = RESPOND;
                end else if (!is_read_q && mem_write_ready) begin
                    mem_write_valid_d   = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    state_d             = RESPOND;
                end
            end
            RESPOND: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!grant_still_valid) begin
                    ptr_d   = (grant_q == CW'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            ptr_q               <= '0;
            is_read_q           <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            rd_ready_q          <= '0;
            wr_ready_q          <= '0;
            rd_data_q           <= '0;
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            ptr_q               <= ptr_d;
            is_read_q           <= is_read_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            rd_ready_q          <= rd_ready_d;
            wr_ready_q          <= wr_ready_d;
            rd_data_q           <= rd_data_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign consumer_write_ready = wr_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign busy                 = (state_q != IDLE);

endmodule
